branch_compare_pipe: RTL and testbench

//  Parametrised, pipelined branch-condition evaluator for the ID/EX branch path.

---
 rtl/branch_compare_pipe_if.sv | 30 +++
 rtl/branch_compare_pipe.sv | 113 +++++++++++
 tb/tb_branch_compare_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_compare_pipe_if.sv
// Evaluation request/response bundle for the pipelined branch comparator.
// The master side issues operands; the slave side returns results and counters.
interface branch_compare_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
);
    logic             InValid;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic [2:0]       Control;
    logic [TAG_W-1:0] InTag;
    logic             Stall;
    logic             Flush;
    logic             OutValid;
    logic             Result;
    logic [TAG_W-1:0] OutTag;
    logic [CNT_W-1:0] TakenCount;
    logic [CNT_W-1:0] EvalCount;

    modport master (
        output InValid, InA, InB, Control, InTag, Stall, Flush,
        input  OutValid, Result, OutTag, TakenCount, EvalCount
    );

    modport slave (
        input  InValid, InA, InB, Control, InTag, Stall, Flush,
        output OutValid, Result, OutTag, TakenCount, EvalCount
    );
endinterface

// File: rtl/branch_compare_pipe.sv
// Pipelined branch-condition evaluator: condition in stage 1, then a
// {valid,result,tag} shift chain, with stall, flush and saturating counters.
module branch_compare_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    branch_compare_pipe_if.slave  bus
);
    localparam int L = LATENCY;

    localparam logic [2:0] C_BEQ  = 3'b000;
    localparam logic [2:0] C_BGEZ = 3'b001;
    localparam logic [2:0] C_BGTZ = 3'b010;
    localparam logic [2:0] C_BLEZ = 3'b011;
    localparam logic [2:0] C_BLTZ = 3'b100;
    localparam logic [2:0] C_BNE  = 3'b101;
    localparam logic [2:0] C_BLTU = 3'b110;
    localparam logic [2:0] C_BGEU = 3'b111;

    logic [L-1:0]            v_q, v_d;
    logic [L-1:0]            r_q, r_d;
    logic [L-1:0][TAG_W-1:0] t_q, t_d;
    logic [CNT_W-1:0]        taken_q, taken_d;
    logic [CNT_W-1:0]        eval_q, eval_d;

    logic a_neg;
    logic a_zero;
    logic a_eq_b;
    logic a_ltu_b;
    logic cond;
    logic retire;

    assign a_neg   = bus.InA[WIDTH-1];
    assign a_zero  = (bus.InA == '0);
    assign a_eq_b  = (bus.InA == bus.InB);
    assign a_ltu_b = (bus.InA < bus.InB);

    // Stage-1 condition decode; zero-relative codes look only at InA.
    always_comb begin
        cond = 1'b0;
        unique case (bus.Control)
            C_BEQ:  cond = a_eq_b;
            C_BGEZ: cond = ~a_neg;
            C_BGTZ: cond = ~a_neg & ~a_zero;
            C_BLEZ: cond = a_neg | a_zero;
            C_BLTZ: cond = a_neg;
            C_BNE:  cond = ~a_eq_b;
            C_BLTU: cond = a_ltu_b;
            C_BGEU: cond = ~a_ltu_b;
        endcase
    end

    // Pipeline next state: flush clears, stall holds, otherwise shift in.
    always_comb begin
        v_d = v_q;
        r_d = r_q;
        t_d = t_q;
        if (bus.Flush) begin
            v_d = '0;
            r_d = '0;
            t_d = '0;
        end else if (!bus.Stall) begin
            v_d[0] = bus.InValid;
            r_d[0] = bus.InValid & cond;
            t_d[0] = bus.InValid ? bus.InTag : '0;
            for (int i = 1; i < L; i++) begin
                v_d[i] = v_q[i-1];
                r_d[i] = r_q[i-1];
                t_d[i] = t_q[i-1];
            end
        end
    end

    // An evaluation retires on the edge that loads it into the last stage.
    always_comb begin
        retire  = ~bus.Flush & ~bus.Stall & v_d[L-1];
        taken_d = taken_q;
        eval_d  = eval_q;
        if (retire && eval_q != '1) begin
            eval_d = eval_q + CNT_W'(1);
        end
        if (retire && r_d[L-1] && taken_q != '1) begin
            taken_d = taken_q + CNT_W'(1);
        end
    end

    // State registers for the stage chain and the statistics counters.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            v_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            taken_q <= '0;
            eval_q  <= '0;
        end else begin
            v_q     <= v_d;
            r_q     <= r_d;
            t_q     <= t_d;
            taken_q <= taken_d;
            eval_q  <= eval_d;
        end
    end

    assign bus.OutValid   = v_q[L-1];
    assign bus.Result     = r_q[L-1];
    assign bus.OutTag     = t_q[L-1];
    assign bus.TakenCount = taken_q;
    assign bus.EvalCount  = eval_q;
endmodule

// File: tb/tb_branch_compare_pipe.sv
// Scoreboard bench: one LATENCY=1/CNT_W=4 instance and one LATENCY=3 instance.
// Stimulus pushes expected {result,tag}; monitors pop on each new retirement.
module tb_branch_compare_pipe;
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BGEZ = 3'b001;
    localparam logic [2:0] BGTZ = 3'b010;
    localparam logic [2:0] BLEZ = 3'b011;
    localparam logic [2:0] BLTZ = 3'b100;
    localparam logic [2:0] BNE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] qa[$];
    logic [5:0] qb[$];

    branch_compare_pipe_if #(.CNT_W(4))  ifa();
    branch_compare_pipe_if #(.CNT_W(16)) ifb();

    branch_compare_pipe #(.LATENCY(1), .CNT_W(4)) u_a (
        .Clock(clk), .Reset_n(rst_n), .bus(ifa)
    );
    branch_compare_pipe #(.LATENCY(3), .CNT_W(16)) u_b (
        .Clock(clk), .Reset_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drvA(input logic v, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
        ifa.InValid = v;
        ifa.Control = c;
        ifa.InA     = a;
        ifa.InB     = b;
        ifa.InTag   = t;
    endtask

    task automatic drvB(input logic v, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
        ifb.InValid = v;
        ifb.Control = c;
        ifb.InA     = a;
        ifb.InB     = b;
        ifb.InTag   = t;
    endtask

    task automatic issA(input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic e);
        drvA(1'b1, c, a, b, t);
        qa.push_back({e, t});
        tick();
        ifa.InValid = 1'b0;
    endtask

    task automatic issB(input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic e, input logic push);
        drvB(1'b1, c, a, b, t);
        if (push) qb.push_back({e, t});
        tick();
        ifb.InValid = 1'b0;
    endtask

    // Monitor A: new retirement = OutValid after an unstalled, unflushed edge.
    initial begin
        logic st;
        logic fl;
        logic [5:0] e;
        forever begin
            @(posedge clk);
            st = ifa.Stall;
            fl = ifa.Flush;
            @(negedge clk);
            if (rst_n && ifa.OutValid && !st && !fl) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL A unexpected output: tag %0h res %0b expected none",
                             ifa.OutTag, ifa.Result);
                end else begin
                    e = qa.pop_front();
                    chk("A tag", 32'(ifa.OutTag), 32'(e[4:0]));
                    chk("A result", 32'(ifa.Result), 32'(e[5]));
                end
            end
        end
    end

    // Monitor B: same rule for the three-stage instance.
    initial begin
        logic st;
        logic fl;
        logic [5:0] e;
        forever begin
            @(posedge clk);
            st = ifb.Stall;
            fl = ifb.Flush;
            @(negedge clk);
            if (rst_n && ifb.OutValid && !st && !fl) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL B unexpected output: tag %0h res %0b expected none",
                             ifb.OutTag, ifb.Result);
                end else begin
                    e = qb.pop_front();
                    chk("B tag", 32'(ifb.OutTag), 32'(e[4:0]));
                    chk("B result", 32'(ifb.Result), 32'(e[5]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drvA(1'b0, BEQ, 0, 0, 0);
        drvB(1'b0, BEQ, 0, 0, 0);
        ifa.Stall = 1'b0;
        ifa.Flush = 1'b0;
        ifb.Stall = 1'b0;
        ifb.Flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst A OutValid", 32'(ifa.OutValid), 0);
        chk("rst A Result", 32'(ifa.Result), 0);
        chk("rst A OutTag", 32'(ifa.OutTag), 0);
        chk("rst A Taken", 32'(ifa.TakenCount), 0);
        chk("rst A Eval", 32'(ifa.EvalCount), 0);
        chk("rst B OutValid", 32'(ifb.OutValid), 0);
        chk("rst B Taken", 32'(ifb.TakenCount), 0);
        chk("rst B Eval", 32'(ifb.EvalCount), 0);
        rst_n = 1'b1;
        tick();

        // Equality and signed/unsigned/zero-relative codes, LATENCY=1.
        issA(BEQ,  32'h1234,     32'h1234,     1,  1);
        issA(BNE,  32'h1234,     32'h1234,     2,  0);
        issA(BLTU, 32'hFFFFFFFF, 32'h1,        3,  0);
        issA(BGEU, 32'hFFFFFFFF, 32'h1,        4,  1);
        issA(BLTZ, 32'hFFFFFFFF, 32'h1,        5,  1);
        issA(BGEZ, 32'hFFFFFFFF, 32'h1,        6,  0);
        issA(BLEZ, 32'h0,        32'h7FFFFFFF, 7,  1);
        issA(BGTZ, 32'h0,        32'h7FFFFFFF, 8,  0);
        issA(BGTZ, 32'h5,        32'h0,        9,  1);
        issA(BLTU, 32'h1,        32'hFFFFFFFF, 10, 1);
        issA(BEQ,  32'h1,        32'h2,        11, 0);
        issA(BNE,  32'h1,        32'h2,        12, 1);
        chk("A Eval after 12", 32'(ifa.EvalCount), 12);
        chk("A Taken after 12", 32'(ifa.TakenCount), 7);

        // Saturation of the 4-bit counters.
        for (int i = 0; i < 3; i++) issA(BEQ, 0, 0, 5'(i), 1);
        chk("A Eval at max", 32'(ifa.EvalCount), 15);
        chk("A Taken at 10", 32'(ifa.TakenCount), 10);
        for (int i = 3; i < 20; i++) issA(BEQ, 0, 0, 5'(i), 1);
        chk("A Eval saturated", 32'(ifa.EvalCount), 15);
        chk("A Taken saturated", 32'(ifa.TakenCount), 15);

        // LATENCY=3 stream with a two-cycle stall mid-stream.
        issB(BEQ, 5, 5, 1, 1, 1);
        chk("B lat edge1", 32'(ifb.OutValid), 0);
        issB(BNE, 5, 5, 2, 0, 1);
        chk("B lat edge2", 32'(ifb.OutValid), 0);
        issB(BLTU, 2, 3, 3, 1, 1);
        chk("B lat edge3 valid", 32'(ifb.OutValid), 1);
        chk("B lat edge3 tag", 32'(ifb.OutTag), 1);
        ifb.Stall = 1'b1;
        drvB(1'b1, BEQ, 0, 0, 9);
        tick();
        chk("B stall1 valid", 32'(ifb.OutValid), 1);
        chk("B stall1 tag", 32'(ifb.OutTag), 1);
        chk("B stall1 Eval", 32'(ifb.EvalCount), 1);
        tick();
        chk("B stall2 tag", 32'(ifb.OutTag), 1);
        chk("B stall2 Eval", 32'(ifb.EvalCount), 1);
        ifb.Stall = 1'b0;
        issB(BGEU, 2, 3, 4, 0, 1);
        issB(BLTZ, 32'h80000000, 0, 5, 1, 1);
        repeat (3) tick();
        chk("B Eval after 5", 32'(ifb.EvalCount), 5);
        chk("B Taken after 5", 32'(ifb.TakenCount), 3);

        // Flush together with stall kills everything in flight.
        issB(BEQ, 7, 7, 10, 1, 1);
        issB(BNE, 1, 1, 11, 0, 0);
        issB(BEQ, 1, 1, 12, 1, 0);
        chk("B pre-flush tag", 32'(ifb.OutTag), 10);
        drvB(1'b1, BEQ, 0, 0, 13);
        ifb.Stall = 1'b1;
        ifb.Flush = 1'b1;
        tick();
        chk("B flush valid", 32'(ifb.OutValid), 0);
        chk("B flush result", 32'(ifb.Result), 0);
        chk("B flush Eval", 32'(ifb.EvalCount), 6);
        chk("B flush Taken", 32'(ifb.TakenCount), 4);
        ifb.Stall = 1'b0;
        ifb.Flush = 1'b0;
        ifb.InValid = 1'b0;
        repeat (4) tick();
        chk("B post-flush valid", 32'(ifb.OutValid), 0);
        chk("B post-flush Eval", 32'(ifb.EvalCount), 6);

        // Asynchronous reset pulse between edges with work in flight.
        drvB(1'b1, BEQ, 0, 0, 20);
        tick();
        drvA(1'b1, BNE, 1, 2, 13);
        qa.push_back({1'b1, 5'd13});
        drvB(1'b1, BEQ, 0, 0, 21);
        tick();
        ifa.InValid = 1'b0;
        ifb.InValid = 1'b0;
        @(negedge clk);
        #1;
        chk("A valid before pulse", 32'(ifa.OutValid), 1);
        rst_n = 1'b0;
        #1;
        chk("pulse A valid", 32'(ifa.OutValid), 0);
        chk("pulse A result", 32'(ifa.Result), 0);
        chk("pulse A tag", 32'(ifa.OutTag), 0);
        chk("pulse A Eval", 32'(ifa.EvalCount), 0);
        chk("pulse A Taken", 32'(ifa.TakenCount), 0);
        chk("pulse B valid", 32'(ifb.OutValid), 0);
        chk("pulse B Eval", 32'(ifb.EvalCount), 0);
        rst_n = 1'b1;
        drvA(1'b1, BEQ, 3, 3, 14);
        qa.push_back({1'b1, 5'd14});
        drvB(1'b1, BEQ, 3, 3, 22);
        qb.push_back({1'b1, 5'd22});
        tick();
        ifa.InValid = 1'b0;
        ifb.InValid = 1'b0;
        chk("post-rst A Eval", 32'(ifa.EvalCount), 1);
        chk("post-rst A Taken", 32'(ifa.TakenCount), 1);
        repeat (2) tick();
        chk("post-rst B Eval", 32'(ifb.EvalCount), 1);
        chk("post-rst B Taken", 32'(ifb.TakenCount), 1);
        repeat (4) tick();
        chk("A queue drained", 32'(qa.size()), 0);
        chk("B queue drained", 32'(qb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
